axi_lite_master: RTL and testbench

- AXI-Lite initiator that turns a simple single-beat valid/ready request from an LSU or IFU into AXI-Lite read or write transactions.
- Returns the read data and an error flag to the requester.
- Sits between the core pipeline and the AXI-Lite memory or peripheral slaves.
- Allows exactly one outstanding transaction and has no bursts or IDs.

---
 rtl/axi_lite_pkg.sv | 29 ++
 rtl/axi_lite_master.sv | 134 +++++++++++++
 tb/tb_axi_lite_master.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types: response codes, master FSM states and default widths.
// Imported by the master and by the slave models.
package axi_lite_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } axi_mst_state_e;

  function automatic logic resp_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator for the LSU/IFU request port.
// All AXI payloads are driven from registers latched when the request fires.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [STRB_WIDTH-1:0] wstrb_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o
);

  axi_mst_state_e        state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  aw_done_q;
  logic                  w_done_q;

  logic aw_fire;
  logic w_fire;
  logic aw_done;
  logic w_done;

  assign req_ready_o = state_q == IDLE;
  assign arvalid_o   = state_q == RD_ADDR;
  assign rready_o    = state_q == RD_DATA;
  assign awvalid_o   = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid_o    = (state_q == WR_REQ) && !w_done_q;
  assign bready_o    = state_q == WR_RESP;
  assign rsp_valid_o = state_q == RSP;

  assign araddr_o = addr_q;
  assign awaddr_o = addr_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;

  // Writes never return data, even if a stale read value is held.
  assign rsp_rdata_o = rdata_q & {DATA_WIDTH{!write_q}};
  assign rsp_err_o   = err_q;

  assign aw_fire = awvalid_o && awready_i;
  assign w_fire  = wvalid_o && wready_i;
  assign aw_done = aw_done_q || aw_fire;
  assign w_done  = w_done_q || w_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
            write_q <= req_write_i;
            state_q <= req_write_i ? WR_REQ : RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready_i) state_q <= RD_DATA;
        end
        RD_DATA: begin
          if (rvalid_i) begin
            rdata_q <= rdata_i;
            err_q   <= resp_err(rresp_i);
            state_q <= RSP;
          end
        end
        WR_REQ: begin
          if (aw_fire) aw_done_q <= 1'b1;
          if (w_fire) w_done_q <= 1'b1;
          if (aw_done && w_done) state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (bvalid_i) begin
            rdata_q <= '0;
            err_q   <= resp_err(bresp_i);
            state_q <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-programmable AXI-Lite slave and
// a transaction-level reference model of the expected responses.
module tb_axi_lite_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_wstrb_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o;
  logic        wready_i = 1'b0;
  logic [1:0]  bresp_i = '0;
  logic        bvalid_i = 1'b0;
  logic        bready_o;

  int tests = 0;
  int fails = 0;

  axi_lite_master dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] araddr;
    logic [31:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int ar_first;
    int aw_first;
    int b_first;
    int rsp_first;
    int aw_cycles;
    int w_cycles;
    int n_ar;
    int n_aw;
    int n_w;
    int n_r;
    int n_b;
    int n_rsp;
    int viol;
    logic timeout;
    logic post_ok;
  } obs_t;

  task automatic slave_idle();
    arready_i = 1'b0;
    rvalid_i = 1'b0;
    awready_i = 1'b0;
    wready_i = 1'b0;
    bvalid_i = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  // Runs one request; cycle 0 is the cycle in which the request fires.
  task automatic run_txn(
    input logic wr, input logic [31:0] addr,
    input logic [31:0] wd, input logic [3:0] ws,
    input int ar_d, input int r_d, input int aw_d,
    input int w_d, input int b_d, input int rsp_d,
    input logic [31:0] sl_rdata, input logic [1:0] sl_resp,
    output obs_t o);
    int k, cyc;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, rsp_cnt;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, done;
    logic ar_f, r_f, aw_f, w_f, b_f, rsp_f;
    logic p_arv, p_awv, p_wv, p_rspv;
    logic p_arf, p_awf, p_wf, p_rspf;
    logic [31:0] p_araddr, p_awaddr, p_wdata, p_rdata;
    logic [3:0] p_wstrb;
    logic p_err;
    o = '{default: 0};
    o.ar_first = -1; o.aw_first = -1;
    o.b_first = -1; o.rsp_first = -1;
    {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, rsp_cnt} = '0;
    {ar_hs, r_hs, aw_hs, w_hs, b_hs, done} = '0;
    {p_arv, p_awv, p_wv, p_rspv} = '0;
    {p_arf, p_awf, p_wf, p_rspf} = '0;
    {p_araddr, p_awaddr, p_wdata, p_rdata} = '0;
    p_wstrb = '0; p_err = 1'b0;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i = addr;
    req_wdata_i = wd;
    req_wstrb_i = ws;
    k = 0;
    while (!req_ready_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    if (!req_ready_o) begin
      req_valid_i = 1'b0;
      o.timeout = 1'b1;
      return;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_write_i = $urandom_range(0, 1);
    req_addr_i = $urandom;
    req_wdata_i = $urandom;
    req_wstrb_i = 4'($urandom);
    cyc = 1;
    while (!done && cyc < 400) begin
      arready_i = arvalid_o && (ar_cnt >= ar_d);
      rvalid_i = ar_hs && !r_hs && (r_cnt >= r_d);
      rdata_i = rvalid_i ? sl_rdata : 32'($urandom);
      rresp_i = wr ? 2'($urandom) : sl_resp;
      awready_i = awvalid_o && (aw_cnt >= aw_d);
      wready_i = wvalid_o && (w_cnt >= w_d);
      bvalid_i = aw_hs && w_hs && !b_hs && (b_cnt >= b_d);
      bresp_i = wr ? sl_resp : 2'($urandom);
      rsp_ready_i = rsp_valid_o && (rsp_cnt >= rsp_d);
      ar_f = arvalid_o && arready_i;
      r_f = rvalid_i && rready_o;
      aw_f = awvalid_o && awready_i;
      w_f = wvalid_o && wready_i;
      b_f = bvalid_i && bready_o;
      rsp_f = rsp_valid_o && rsp_ready_i;
      if (req_ready_o) o.viol++;
      if (arvalid_o && o.ar_first < 0) o.ar_first = cyc;
      if (awvalid_o && o.aw_first < 0) o.aw_first = cyc;
      if (bready_o && o.b_first < 0) o.b_first = cyc;
      if (rsp_valid_o && o.rsp_first < 0) o.rsp_first = cyc;
      if (awvalid_o) o.aw_cycles++;
      if (wvalid_o) o.w_cycles++;
      if (arvalid_o && ar_hs) o.viol++;
      if (awvalid_o && aw_hs) o.viol++;
      if (wvalid_o && w_hs) o.viol++;
      if (rready_o && !(ar_hs && !r_hs)) o.viol++;
      if (bready_o && !(aw_hs && w_hs && !b_hs)) o.viol++;
      if (p_arv && !p_arf && (!arvalid_o || araddr_o !== p_araddr))
        o.viol++;
      if (p_awv && !p_awf && (!awvalid_o || awaddr_o !== p_awaddr))
        o.viol++;
      if (p_wv && !p_wf &&
          (!wvalid_o || wdata_o !== p_wdata || wstrb_o !== p_wstrb))
        o.viol++;
      if (p_rspv && !p_rspf && (!rsp_valid_o ||
          rsp_rdata_o !== p_rdata || rsp_err_o !== p_err))
        o.viol++;
      if (ar_f) begin o.n_ar++; o.araddr = araddr_o; end
      if (aw_f) begin o.n_aw++; o.awaddr = awaddr_o; end
      if (w_f) begin
        o.n_w++; o.wdata = wdata_o; o.wstrb = wstrb_o;
      end
      if (r_f) o.n_r++;
      if (b_f) o.n_b++;
      if (rsp_f) begin
        o.n_rsp++; o.rdata = rsp_rdata_o; o.err = rsp_err_o;
      end
      p_arv = arvalid_o; p_awv = awvalid_o;
      p_wv = wvalid_o; p_rspv = rsp_valid_o;
      p_arf = ar_f; p_awf = aw_f; p_wf = w_f; p_rspf = rsp_f;
      p_araddr = araddr_o; p_awaddr = awaddr_o;
      p_wdata = wdata_o; p_wstrb = wstrb_o;
      p_rdata = rsp_rdata_o; p_err = rsp_err_o;
      @(posedge clk_i);
      if (p_arv && !ar_f) ar_cnt++;
      if (ar_hs) r_cnt++;
      if (p_awv && !aw_f) aw_cnt++;
      if (p_wv && !w_f) w_cnt++;
      if (aw_hs && w_hs) b_cnt++;
      if (p_rspv) rsp_cnt++;
      if (ar_f) ar_hs = 1'b1;
      if (r_f) r_hs = 1'b1;
      if (aw_f) aw_hs = 1'b1;
      if (w_f) w_hs = 1'b1;
      if (b_f) b_hs = 1'b1;
      if (rsp_f) done = 1'b1;
      @(negedge clk_i);
      cyc++;
    end
    slave_idle();
    o.timeout = !done;
    o.post_ok = !rsp_valid_o && req_ready_o;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    tests++;
    if ({req_ready_o, arvalid_o, awvalid_o, wvalid_o,
         rready_o, bready_o, rsp_valid_o} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_ctrl got=%b want=1000000",
               {req_ready_o, arvalid_o, awvalid_o, wvalid_o,
                rready_o, bready_o, rsp_valid_o});
    end
    tests++;
    if ({araddr_o, awaddr_o, wdata_o, wstrb_o, rsp_rdata_o, rsp_err_o}
        !== '0) begin
      fails++;
      $display("FAIL reset_regs got araddr=%h wdata=%h rdata=%h want 0",
               araddr_o, wdata_o, rsp_rdata_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_read_zero_wait();
    obs_t o;
    run_txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0,
            32'hDEAD_BEEF, 2'b00, o);
    tests++;
    if (o.timeout || o.ar_first != 1 || o.rsp_first != 3) begin
      fails++;
      $display("FAIL rd0_latency got ar=%0d rsp=%0d to=%0b want ar=1 rsp=3",
               o.ar_first, o.rsp_first, o.timeout);
    end
    tests++;
    if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0 ||
        o.araddr !== 32'h8000_0000) begin
      fails++;
      $display("FAIL rd0_data got rdata=%h err=%b addr=%h want deadbeef 0 80000000",
               o.rdata, o.err, o.araddr);
    end
    tests++;
    if (o.n_rsp != 1 || !o.post_ok || o.viol != 0) begin
      fails++;
      $display("FAIL rd0_proto got nrsp=%0d post=%b viol=%0d want 1 1 0",
               o.n_rsp, o.post_ok, o.viol);
    end
  endtask

  task automatic test_write_w_first();
    obs_t o;
    run_txn(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 0, 0, 3, 0, 0, 0,
            32'h0, 2'b00, o);
    tests++;
    if (o.timeout || o.w_cycles != 1 || o.aw_cycles != 4 ||
        o.b_first != 5) begin
      fails++;
      $display("FAIL wfirst_timing got w=%0d aw=%0d b=%0d want 1 4 5",
               o.w_cycles, o.aw_cycles, o.b_first);
    end
    tests++;
    if (o.awaddr !== 32'h8000_0010 || o.wdata !== 32'h1234_5678 ||
        o.wstrb !== 4'b0011) begin
      fails++;
      $display("FAIL wfirst_payload got %h %h %b want 80000010 12345678 0011",
               o.awaddr, o.wdata, o.wstrb);
    end
    tests++;
    if (o.rdata !== 32'h0 || o.err !== 1'b0 || o.n_rsp != 1 ||
        o.viol != 0) begin
      fails++;
      $display("FAIL wfirst_rsp got rdata=%h err=%b n=%0d viol=%0d want 0 0 1 0",
               o.rdata, o.err, o.n_rsp, o.viol);
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic [1:0] rr [3];
    rr = '{2'b10, 2'b01, 2'b11};
    foreach (rr[i]) begin
      run_txn(1'b0, 32'h4000_0000 + 32'(i * 4), 32'h0, 4'h0,
              1, 2, 0, 0, 0, 0, 32'hA5A5_0000 + 32'(i), rr[i], o);
      tests++;
      if (o.timeout || o.err !== 1'b1 ||
          o.rdata !== 32'hA5A5_0000 + 32'(i)) begin
        fails++;
        $display("FAIL rd_err%0d got err=%b rdata=%h want 1 %h",
                 i, o.err, o.rdata, 32'hA5A5_0000 + 32'(i));
      end
    end
    run_txn(1'b1, 32'h4000_0100, 32'hFFFF_FFFF, 4'hF, 0, 0, 1, 2, 1, 0,
            32'h0, 2'b11, o);
    tests++;
    if (o.timeout || o.err !== 1'b1 || o.rdata !== 32'h0) begin
      fails++;
      $display("FAIL wr_err got err=%b rdata=%h want 1 0", o.err, o.rdata);
    end
  endtask

  task automatic test_same_cycle();
    obs_t o;
    run_txn(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1100, 0, 0, 0, 0, 0, 0,
            32'h0, 2'b00, o);
    tests++;
    if (o.timeout || o.aw_cycles != 1 || o.w_cycles != 1 ||
        o.b_first != 2 || o.n_aw != 1 || o.n_w != 1) begin
      fails++;
      $display("FAIL same_cycle got aw=%0d w=%0d b=%0d want 1 1 2",
               o.aw_cycles, o.w_cycles, o.b_first);
    end
  endtask

  task automatic test_random_stalls();
    obs_t o;
    logic wr;
    logic [31:0] addr, wd, rd;
    logic [3:0] ws;
    logic [1:0] rs;
    logic [31:0] exp_rdata;
    logic exp_err;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      addr = $urandom;
      wd = $urandom;
      ws = 4'($urandom);
      rd = $urandom;
      rs = 2'($urandom_range(0, 3));
      run_txn(wr, addr, wd, ws,
              $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), (n == 0) ? 5 : $urandom_range(0, 7),
              rd, rs, o);
      exp_rdata = wr ? 32'h0 : rd;
      exp_err = rs != 2'b00;
      tests++;
      if (o.timeout || o.rdata !== exp_rdata || o.err !== exp_err) begin
        fails++;
        $display("FAIL rnd%0d_rsp got rdata=%h err=%b to=%b want %h %b",
                 n, o.rdata, o.err, o.timeout, exp_rdata, exp_err);
      end
      tests++;
      if (wr ? (o.n_aw != 1 || o.n_w != 1 || o.n_b != 1 || o.n_ar != 0 ||
                o.awaddr !== addr || o.wdata !== wd || o.wstrb !== ws)
             : (o.n_ar != 1 || o.n_r != 1 || o.n_aw != 0 || o.n_w != 0 ||
                o.araddr !== addr)) begin
        fails++;
        $display("FAIL rnd%0d_axi got ar=%0d aw=%0d w=%0d addr=%h/%h want addr=%h",
                 n, o.n_ar, o.n_aw, o.n_w, o.araddr, o.awaddr, addr);
      end
      tests++;
      if (o.n_rsp != 1 || !o.post_ok || o.viol != 0) begin
        fails++;
        $display("FAIL rnd%0d_proto got nrsp=%0d post=%b viol=%0d want 1 1 0",
                 n, o.n_rsp, o.post_ok, o.viol);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int k;
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i = 32'h1000_0000;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    k = 0;
    while (!arvalid_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    arready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    arready_i = 1'b0;
    tests++;
    if (rready_o !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_rddata got rready=%b want 1", rready_o);
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o,
         rsp_valid_o, req_ready_o, rsp_rdata_o} !== {7'b0000001, 32'h0}) begin
      fails++;
      $display("FAIL rstmid_async got ctrl=%b want 0000001",
               {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o,
                rsp_valid_o, req_ready_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests++;
    if (req_ready_o !== 1'b1 || arvalid_o !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_release got ready=%b arvalid=%b want 1 0",
               req_ready_o, arvalid_o);
    end
    run_txn(1'b0, 32'h1000_0004, 32'h0, 4'h0, 2, 3, 0, 0, 0, 1,
            32'h0BAD_F00D, 2'b00, o);
    tests++;
    if (o.timeout || o.rdata !== 32'h0BAD_F00D || o.err !== 1'b0 ||
        o.araddr !== 32'h1000_0004 || o.viol != 0) begin
      fails++;
      $display("FAIL rstmid_after got rdata=%h err=%b addr=%h want 0badf00d 0 10000004",
               o.rdata, o.err, o.araddr);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_w_first();
    test_errors();
    test_same_cycle();
    test_random_stalls();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
